uart_rcvr: RTL and testbench
============================

// Module: uart_rcvr
// PURPOSE
//  UART receiver: serial-to-parallel counterpart of the UART transmitter. It shares the
//  same clk (OVER_SAMP x baud) and the same frame format.
//  Frame: 1 start bit (0), WD_SIZE data bits LSB first, 1 stop bit (1). No parity.
//  It synchronises the serial input, finds the start bit, samples each bit at mid-bit,
//  and presents the word to the bus with a ready/read handshake and error flags.
// PARAMETERS
//  WD_SIZE    8   data bits per frame (1..16)
//  OVER_SAMP  16  clk cycles per bit; must be even and >= 4
// PORTS
//  clk          in   1        clock, OVER_SAMP x baud rate
//  rstn         in   1        reset, asynchronous, active-low
//  seri_data_i  in   1        serial line, async to clk, idles high
//  read_i       in   1        bus has consumed bus_data_o; 1-cycle pulse
//  bus_data_o   out  WD_SIZE  last received word
//  data_rdy_o   out  1        unread word held in bus_data_o
//  frame_err_o  out  1        stop bit of last completed word sampled 0
//  ovrn_err_o   out  1        word completed while data_rdy_o=1; sticky
//  busy_o       out  1        FSM not in IDLE
// BEHAVIOUR
//  Reset:
//   - all outputs 0; FSM=IDLE; counters 0; both synchroniser flops =1 (line idle).
//   - A reset mid-frame abandons the frame; nothing is delivered.
//  Synchroniser: 2-flop sync gives rx_s; all logic uses rx_s only, never seri_data_i.
//  FSM states: IDLE, START, DATA, STOP, WAIT_HI.
//  IDLE: rx_s=0 at cycle t0 -> START. cnt_ovsmp=0 and bit_cnt=0 at t0+1.
//  START: sample at cnt_ovsmp==OVER_SAMP/2-1, i.e. at t0+OVER_SAMP/2.
//   - rx_s=0 -> DATA; cnt_ovsmp reloads 0.
//   - rx_s=1 -> glitch; back to IDLE; no flags change.
//  DATA: sample at every cnt_ovsmp==OVER_SAMP-1.
//   - bit i (0-based) is sampled at t0+OVER_SAMP/2+OVER_SAMP*(i+1).
//   - shift right into shreg MSB, so the LSB arrives first.
//   - after bit WD_SIZE-1 -> STOP.
//  STOP: sample at t0+OVER_SAMP/2+OVER_SAMP*(WD_SIZE+1); this is completion cycle tc.
//   - At tc+1: bus_data_o<=shreg, data_rdy_o<=1, frame_err_o<=~rx_s.
//   - Word is delivered even on framing error.
//   - Stop=1 -> IDLE. Stop=0 -> WAIT_HI.
//  WAIT_HI: stay until rx_s=1, then -> IDLE. Covers a break or a line held low.
//  Handshake:
//   - read_i with data_rdy_o=1: data_rdy_o and ovrn_err_o clear next cycle.
//   - read_i with data_rdy_o=0: ignored.
//  Overrun: completion while data_rdy_o=1 and no read_i in the same cycle.
//   - ovrn_err_o<=1 and the new word overwrites bus_data_o.
//  Simultaneous read_i and completion: new word wins.
//   - data_rdy_o stays 1; no overrun; ovrn_err_o clears.
//  Counters:
//   - cnt_ovsmp width clog2(OVER_SAMP); wraps OVER_SAMP-1 -> 0.
//   - bit_cnt width clog2(WD_SIZE+1).
//   - Both held at 0 in IDLE and WAIT_HI.
//  Latency: with OVER_SAMP=16, WD_SIZE=8, data_rdy_o rises at t0+153.
//   - That is 155 clk after the seri_data_i falling edge, counting 2 sync cycles.
//  bus_data_o and frame_err_o change only at completion; stable otherwise.
// TESTING
//  1 Send 0xA5, clean frame -> data_rdy_o=1 at t0+153; bus_data_o=8'hA5; no errors.
//  2 Low glitch of 5 clk on idle line -> busy_o pulses, returns to IDLE.
//    data_rdy_o stays 0; no flags.
//  3 Send 0x3C with stop bit=0, line high 16 clk later -> bus_data_o=8'h3C.
//    frame_err_o=1; FSM passes through WAIT_HI; next 0x55 frame gives frame_err_o=0.
//  4 Send 0x11 then 0x22, no read_i -> ovrn_err_o=1, bus_data_o=8'h22.
//    read_i clears data_rdy_o and ovrn_err_o.
//  5 read_i in the exact completion cycle of 2nd word -> data_rdy_o stays 1.
//    ovrn_err_o=0; bus_data_o holds the new word.
//  6 rstn low during bit 4 of a frame, release with line high -> all outputs 0, IDLE.
//    Next 0xFF frame received correctly.

Source files
------------

// File: rtl/uart_rcvr.sv
// UART receiver: 2-flop sync, mid-bit sampling; word out at t0+OVER_SAMP/2+OVER_SAMP*(WD_SIZE+1)+1.
// No backpressure on the line: an unread word is overwritten and ovrn_err_o is raised.
module uart_rcvr #(
    parameter int WD_SIZE   = 8,
    parameter int OVER_SAMP = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               seri_data_i,
    input  logic               read_i,
    output logic [WD_SIZE-1:0] bus_data_o,
    output logic               data_rdy_o,
    output logic               frame_err_o,
    output logic               ovrn_err_o,
    output logic               busy_o
);

    localparam int CW = $clog2(OVER_SAMP);
    localparam int BW = $clog2(WD_SIZE + 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVER_SAMP / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVER_SAMP - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WD_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt_ovsmp, cnt_ovsmp_n;
    logic [BW-1:0]      bit_cnt, bit_cnt_n;
    logic [WD_SIZE-1:0] shreg;
    logic [WD_SIZE:0]   sh_cat;
    logic               sync1, rx_s;
    logic               shift_en;
    logic               done;

    // Sync flops reset to the idle level so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= seri_data_i;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt_ovsmp <= '0;
            bit_cnt   <= '0;
        end else begin
            state     <= state_n;
            cnt_ovsmp <= cnt_ovsmp_n;
            bit_cnt   <= bit_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_ovsmp_n = cnt_ovsmp;
        bit_cnt_n   = bit_cnt;
        shift_en    = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                cnt_ovsmp_n = '0;
                bit_cnt_n   = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt_ovsmp == CNT_MID) begin
                    cnt_ovsmp_n = '0;
                    state_n     = rx_s ? IDLE : DATA;
                end else begin
                    cnt_ovsmp_n = cnt_ovsmp + 1'b1;
                end
            end
            DATA: begin
                if (cnt_ovsmp == CNT_LAST) begin
                    cnt_ovsmp_n = '0;
                    shift_en    = 1'b1;
                    bit_cnt_n   = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) state_n = STOP;
                end else begin
                    cnt_ovsmp_n = cnt_ovsmp + 1'b1;
                end
            end
            STOP: begin
                if (cnt_ovsmp == CNT_LAST) begin
                    cnt_ovsmp_n = '0;
                    done        = 1'b1;
                    state_n     = rx_s ? IDLE : WAIT_HI;
                end else begin
                    cnt_ovsmp_n = cnt_ovsmp + 1'b1;
                end
            end
            WAIT_HI: begin
                cnt_ovsmp_n = '0;
                bit_cnt_n   = '0;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                state_n     = IDLE;
                cnt_ovsmp_n = '0;
                bit_cnt_n   = '0;
            end
        endcase
    end

    // Concatenate-then-slice keeps the shift legal for WD_SIZE == 1.
    assign sh_cat = {rx_s, shreg};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg <= '0;
        end else if (shift_en) begin
            shreg <= sh_cat[WD_SIZE:1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus_data_o  <= '0;
            data_rdy_o  <= 1'b0;
            frame_err_o <= 1'b0;
            ovrn_err_o  <= 1'b0;
        end else if (done) begin
            bus_data_o  <= shreg;
            data_rdy_o  <= 1'b1;
            frame_err_o <= ~rx_s;
            // A read landing on the completion cycle consumes the old word, so no overrun.
            if (data_rdy_o) ovrn_err_o <= ~read_i;
        end else if (read_i && data_rdy_o) begin
            data_rdy_o <= 1'b0;
            ovrn_err_o <= 1'b0;
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_uart_rcvr.sv
module tb_uart_rcvr;

    logic       clk;
    logic       rstn;
    logic       seri_data_i;
    logic       read_i;
    logic [7:0] bus_data_o;
    logic       data_rdy_o;
    logic       frame_err_o;
    logic       ovrn_err_o;
    logic       busy_o;

    int errors = 0;
    int checks = 0;

    uart_rcvr #(.WD_SIZE(8), .OVER_SAMP(16)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .seri_data_i (seri_data_i),
        .read_i      (read_i),
        .bus_data_o  (bus_data_o),
        .data_rdy_o  (data_rdy_o),
        .frame_err_o (frame_err_o),
        .ovrn_err_o  (ovrn_err_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       rd;
        logic [7:0] e_data;
        logic       e_rdy;
        logic       e_ferr;
        logic       e_ovrn;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called #1 after a posedge; returns #1 after the posedge ending the last segment.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int extra_low);
        seri_data_i = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            seri_data_i = d[i];
            repeat (16) @(posedge clk);
            #1;
        end
        seri_data_i = stop;
        repeat (16) @(posedge clk);
        #1;
        if (!stop) begin
            repeat (extra_low) @(posedge clk);
            #1;
        end
        seri_data_i = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic       seen_busy;
        logic [7:0] pd;

        vecs[0] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1};

        rstn        = 1'b0;
        seri_data_i = 1'b1;
        read_i      = 1'b0;
        idle(3);
        chk("rst_data", 32'(bus_data_o), 32'h0);
        chk("rst_rdy",  32'(data_rdy_o), 32'h0);
        chk("rst_ferr", 32'(frame_err_o), 32'h0);
        chk("rst_ovrn", 32'(ovrn_err_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        rstn = 1'b1;
        idle(3);

        // Short low glitch: START sees the line high again at mid-bit.
        seri_data_i = 1'b0;
        idle(5);
        seri_data_i = 1'b1;
        seen_busy = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy_o) seen_busy = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("glitch_busy_seen", 32'(seen_busy), 32'h1);
        chk("glitch_busy_end",  32'(busy_o), 32'h0);
        chk("glitch_rdy",       32'(data_rdy_o), 32'h0);
        chk("glitch_ferr",      32'(frame_err_o), 32'h0);
        chk("glitch_ovrn",      32'(ovrn_err_o), 32'h0);

        // Line falls just after edge 0; rx_s is low for the cycle ending at edge 3, word at edge 155.
        fork
            send_frame(8'hA5, 1'b1, 0);
            begin
                repeat (154) @(posedge clk);
                @(negedge clk);
                chk("lat_rdy_early", 32'(data_rdy_o), 32'h0);
                @(posedge clk);
                @(negedge clk);
                chk("lat_rdy_on", 32'(data_rdy_o), 32'h1);
            end
        join
        idle(4);
        chk("a5_data", 32'(bus_data_o), 32'hA5);
        chk("a5_ferr", 32'(frame_err_o), 32'h0);
        chk("a5_ovrn", 32'(ovrn_err_o), 32'h0);
        chk("a5_busy", 32'(busy_o), 32'h0);
        read_i = 1'b1;
        idle(1);
        read_i = 1'b0;
        chk("a5_read_rdy", 32'(data_rdy_o), 32'h0);

        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].data, vecs[v].stop, 16);
            if (!vecs[v].stop) begin
                @(negedge clk);
                chk($sformatf("v%0d_wait_hi_busy", v), 32'(busy_o), 32'h1);
                @(posedge clk);
                #1;
            end
            idle(4);
            chk($sformatf("v%0d_data", v), 32'(bus_data_o), 32'(vecs[v].e_data));
            chk($sformatf("v%0d_rdy", v),  32'(data_rdy_o), 32'(vecs[v].e_rdy));
            chk($sformatf("v%0d_ferr", v), 32'(frame_err_o), 32'(vecs[v].e_ferr));
            chk($sformatf("v%0d_ovrn", v), 32'(ovrn_err_o), 32'(vecs[v].e_ovrn));
            chk($sformatf("v%0d_busy", v), 32'(busy_o), 32'h0);
            if (vecs[v].rd) begin
                read_i = 1'b1;
                idle(1);
                read_i = 1'b0;
                chk($sformatf("v%0d_rd_rdy", v),  32'(data_rdy_o), 32'h0);
                chk($sformatf("v%0d_rd_ovrn", v), 32'(ovrn_err_o), 32'h0);
                chk($sformatf("v%0d_rd_data", v), 32'(bus_data_o), 32'(vecs[v].e_data));
            end
        end

        // Read in the exact completion cycle while an overrun is pending: new word wins.
        fork
            send_frame(8'h33, 1'b1, 0);
            begin
                repeat (154) @(posedge clk);
                #1;
                read_i = 1'b1;
                @(posedge clk);
                #1;
                read_i = 1'b0;
            end
        join
        idle(4);
        chk("sim_rdy",  32'(data_rdy_o), 32'h1);
        chk("sim_ovrn", 32'(ovrn_err_o), 32'h0);
        chk("sim_data", 32'(bus_data_o), 32'h33);

        send_frame(8'hC3, 1'b0, 16);
        idle(4);
        chk("c3_ferr", 32'(frame_err_o), 32'h1);
        chk("c3_ovrn", 32'(ovrn_err_o), 32'h1);

        // Reset in the middle of data bit 4.
        pd = 8'h99;
        seri_data_i = 1'b0;
        idle(16);
        for (int i = 0; i < 4; i++) begin
            seri_data_i = pd[i];
            idle(16);
        end
        seri_data_i = pd[4];
        idle(8);
        chk("mid_busy_pre", 32'(busy_o), 32'h1);
        rstn        = 1'b0;
        seri_data_i = 1'b1;
        #1;
        chk("mid_rst_data", 32'(bus_data_o), 32'h0);
        chk("mid_rst_rdy",  32'(data_rdy_o), 32'h0);
        chk("mid_rst_ferr", 32'(frame_err_o), 32'h0);
        chk("mid_rst_ovrn", 32'(ovrn_err_o), 32'h0);
        chk("mid_rst_busy", 32'(busy_o), 32'h0);
        idle(4);
        rstn = 1'b1;
        idle(200);
        chk("post_rst_rdy",  32'(data_rdy_o), 32'h0);
        chk("post_rst_busy", 32'(busy_o), 32'h0);

        send_frame(8'hFF, 1'b1, 0);
        idle(4);
        chk("ff_data", 32'(bus_data_o), 32'hFF);
        chk("ff_rdy",  32'(data_rdy_o), 32'h1);
        chk("ff_ferr", 32'(frame_err_o), 32'h0);
        chk("ff_ovrn", 32'(ovrn_err_o), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
